adc_avg_mc: RTL and testbench



---
 rtl/adc_avg_mc.sv | 137 +++++++++++++
 tb/tb_adc_avg_mc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_mc.sv
// Multi-channel power-of-two averaging filter for interleaved ADC samples.
// Supports sliding moving average and block (decimating) average, 2-cycle latency.
module adc_avg_mc #(
    parameter int DATA_NBIT  = 12,
    parameter int NCH        = 4,
    parameter int CH_NBIT    = 2,
    parameter int MAX_LOG2N  = 4,
    parameter int LOG2N_NBIT = $clog2(MAX_LOG2N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_strobe,
    input  logic [CH_NBIT-1:0]    i_ch,
    input  logic [DATA_NBIT-1:0]  i_inst_data,
    input  logic                  i_cfg_load,
    input  logic [LOG2N_NBIT-1:0] i_cfg_log2n,
    input  logic                  i_cfg_mode,
    input  logic                  i_cfg_round,
    output logic                  o_strobe,
    output logic [CH_NBIT-1:0]    o_ch,
    output logic [DATA_NBIT-1:0]  o_avg_data
);

    localparam int DEPTH     = 1 << MAX_LOG2N;
    localparam int SUM_NBIT  = DATA_NBIT + MAX_LOG2N;
    localparam int RES_NBIT  = SUM_NBIT + 1;
    localparam int FILL_NBIT = MAX_LOG2N + 1;
    localparam int MAX_VAL   = (1 << DATA_NBIT) - 1;

    logic [LOG2N_NBIT-1:0] cfg_log2n_q;
    logic                  cfg_mode_q;
    logic                  cfg_round_q;

    logic [DATA_NBIT-1:0] hist_q   [NCH][DEPTH];
    logic [MAX_LOG2N-1:0] wr_ptr_q [NCH];
    logic [SUM_NBIT-1:0]  sum_q    [NCH];
    logic [FILL_NBIT-1:0] fill_q   [NCH];

    logic                 s1_valid_q;
    logic [CH_NBIT-1:0]   s1_ch_q;
    logic [DATA_NBIT-1:0] s1_data_q;

    logic [FILL_NBIT-1:0] n_val;
    logic [FILL_NBIT-1:0] fill_cur;
    logic [FILL_NBIT-1:0] fill_inc;
    logic [FILL_NBIT-1:0] fill_next;
    logic [MAX_LOG2N-1:0] ptr_cur;
    logic [MAX_LOG2N-1:0] rd_ptr;
    logic [DATA_NBIT-1:0] old_sample;
    logic [SUM_NBIT-1:0]  sum_new;
    logic [SUM_NBIT-1:0]  sum_next;
    logic [RES_NBIT-1:0]  rnd;
    logic [RES_NBIT-1:0]  avg_wide;
    logic [DATA_NBIT-1:0] avg;
    logic                 fire;
    logic                 flush;

    assign flush = rst || i_cfg_load;

    // State is read and written in the same stage, so back-to-back samples on one
    // channel see each other's updates without any explicit bypass.
    always_comb begin
        n_val      = FILL_NBIT'(1) << cfg_log2n_q;
        fill_cur   = fill_q[s1_ch_q];
        ptr_cur    = wr_ptr_q[s1_ch_q];
        rd_ptr     = ptr_cur - n_val[MAX_LOG2N-1:0];
        old_sample = '0;
        if (!cfg_mode_q && fill_cur >= n_val) begin
            old_sample = hist_q[s1_ch_q][rd_ptr];
        end
        sum_new  = sum_q[s1_ch_q] + SUM_NBIT'(s1_data_q) - SUM_NBIT'(old_sample);
        fill_inc = fill_cur + FILL_NBIT'(1);

        if (cfg_mode_q) begin
            fire      = (fill_inc == n_val);
            fill_next = fire ? '0 : fill_inc;
            sum_next  = fire ? '0 : sum_new;
        end else begin
            fire      = (fill_inc >= n_val);
            fill_next = (fill_inc > n_val) ? n_val : fill_inc;
            sum_next  = sum_new;
        end

        rnd = '0;
        if (cfg_round_q && cfg_log2n_q != '0) begin
            rnd = RES_NBIT'(1) << (cfg_log2n_q - LOG2N_NBIT'(1));
        end
        avg_wide = (RES_NBIT'(sum_new) + rnd) >> cfg_log2n_q;
        avg      = (avg_wide > RES_NBIT'(MAX_VAL)) ? '1 : avg_wide[DATA_NBIT-1:0];
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_valid_q <= 1'b0;
            o_strobe   <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                wr_ptr_q[c] <= '0;
                sum_q[c]    <= '0;
                fill_q[c]   <= '0;
            end
            if (rst) begin
                cfg_log2n_q <= '0;
                cfg_mode_q  <= 1'b0;
                cfg_round_q <= 1'b0;
                o_ch        <= '0;
                o_avg_data  <= '0;
            end else begin
                cfg_log2n_q <= (i_cfg_log2n > LOG2N_NBIT'(MAX_LOG2N)) ?
                               LOG2N_NBIT'(MAX_LOG2N) : i_cfg_log2n;
                cfg_mode_q  <= i_cfg_mode;
                cfg_round_q <= i_cfg_round;
            end
        end else begin
            s1_valid_q <= i_strobe;
            s1_ch_q    <= i_ch;
            s1_data_q  <= i_inst_data;
            o_strobe   <= s1_valid_q && fire;
            if (s1_valid_q) begin
                wr_ptr_q[s1_ch_q] <= ptr_cur + MAX_LOG2N'(1);
                sum_q[s1_ch_q]    <= sum_next;
                fill_q[s1_ch_q]   <= fill_next;
                if (fire) begin
                    o_ch       <= s1_ch_q;
                    o_avg_data <= avg;
                end
            end
        end
    end

    // History is only read once fill shows it was written, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!flush && s1_valid_q) begin
            hist_q[s1_ch_q][ptr_cur] <= s1_data_q;
        end
    end

endmodule

// File: tb/tb_adc_avg_mc.sv
// Directed self-checking bench for adc_avg_mc: warm-up, block mode, interleaving,
// saturation, config clamp, mid-stream reconfiguration and reset.
module tb_adc_avg_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_strobe = 1'b0;
    logic [1:0]  i_ch = '0;
    logic [11:0] i_inst_data = '0;
    logic        i_cfg_load = 1'b0;
    logic [2:0]  i_cfg_log2n = '0;
    logic        i_cfg_mode = 1'b0;
    logic        i_cfg_round = 1'b0;
    logic        o_strobe;
    logic [1:0]  o_ch;
    logic [11:0] o_avg_data;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adc_avg_mc dut (
        .clk         (clk),
        .rst         (rst),
        .i_strobe    (i_strobe),
        .i_ch        (i_ch),
        .i_inst_data (i_inst_data),
        .i_cfg_load  (i_cfg_load),
        .i_cfg_log2n (i_cfg_log2n),
        .i_cfg_mode  (i_cfg_mode),
        .i_cfg_round (i_cfg_round),
        .o_strobe    (o_strobe),
        .o_ch        (o_ch),
        .o_avg_data  (o_avg_data)
    );

    // One clock cycle of stimulus; outputs are then sampled 1ns after the edge.
    task automatic cyc(input logic ld, input logic st, input int ch, input int d);
        logic [31:0] chv;
        logic [31:0] dv;
        chv = ch;
        dv  = d;
        @(negedge clk);
        i_cfg_load  = ld;
        i_strobe    = st;
        i_ch        = chv[1:0];
        i_inst_data = dv[11:0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk_data(input string tag, input int ed);
        total++;
        assert (o_avg_data === 12'(ed)) else begin
            fails++;
            $error("FAIL %s data: got %0d expected %0d", tag, o_avg_data, ed);
        end
    endtask

    task automatic chk(input string tag, input logic es, input int ech, input int ed);
        total++;
        assert (o_strobe === es) else begin
            fails++;
            $error("FAIL %s strobe: got %0b expected %0b", tag, o_strobe, es);
        end
        if (es) begin
            total++;
            assert (o_ch === 2'(ech)) else begin
                fails++;
                $error("FAIL %s ch: got %0d expected %0d", tag, o_ch, ech);
            end
            chk_data(tag, ed);
        end
    endtask

    task automatic load(input int l2n, input logic mode, input logic rnd);
        logic [31:0] lv;
        lv          = l2n;
        i_cfg_log2n = lv[2:0];
        i_cfg_mode  = mode;
        i_cfg_round = rnd;
        cyc(1'b1, 1'b0, 0, 0);
    endtask

    int blk_s [8] = '{1, 2, 3, 4, 5, 6, 7, 9};
    int blk_t [8] = '{0, 0, 0, 2, 0, 0, 0, 6};
    int blk_r [8] = '{0, 0, 0, 3, 0, 0, 0, 7};

    initial begin
        // Reset
        cyc(1'b0, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0);
        chk("reset", 1'b0, 0, 0);
        chk_data("reset", 0);
        total++;
        assert (o_ch === 2'd0) else begin
            fails++;
            $error("FAIL reset ch: got %0d expected 0", o_ch);
        end
        rst = 1'b0;

        // 1: moving average N=4 with warm-up
        load(2, 1'b0, 1'b0);
        chk("t1_load", 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 0, 4);
        cyc(1'b0, 1'b1, 0, 8);   chk("t1_s4", 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 0, 12);  chk("t1_s8", 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 0, 16);  chk("t1_s12", 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 0, 20);  chk("t1_s16", 1'b1, 0, 10);
        cyc(1'b0, 1'b0, 0, 0);   chk("t1_s20", 1'b1, 0, 14);
        cyc(1'b0, 1'b0, 0, 0);   chk("t1_idle", 1'b0, 0, 0);
        chk_data("t1_hold", 14);

        // 2: block average N=4, truncate then round
        for (int pass = 0; pass < 2; pass++) begin
            load(2, 1'b1, pass[0]);
            for (int i = 0; i <= 8; i++) begin
                cyc(1'b0, i < 8, 1, (i < 8) ? blk_s[i] : 0);
                if (i > 0) begin
                    chk(pass == 0 ? "t2_trunc" : "t2_round",
                        (i == 4) || (i == 8), 1,
                        pass == 0 ? blk_t[i-1] : blk_r[i-1]);
                end
            end
        end

        // 3: four channels interleaved, N=8
        load(3, 1'b0, 1'b0);
        for (int i = 0; i <= 48; i++) begin
            cyc(1'b0, i < 48, i % 4, 100 * (i % 4) + 1);
            if (i > 0) begin
                chk("t3_interleave", ((i - 1) / 4) >= 7, (i - 1) % 4, 100 * ((i - 1) % 4) + 1);
            end
        end

        // 4: full-scale saturation boundary, N=16 with rounding, pointer wraps
        load(4, 1'b0, 1'b1);
        for (int i = 0; i <= 40; i++) begin
            cyc(1'b0, i < 40, 2, 4095);
            if (i > 0) chk("t4_fullscale", (i - 1) >= 15, 2, 4095);
        end

        // Out-of-range window clamps to N=16
        load(7, 1'b1, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            cyc(1'b0, i < 16, 3, i);
            if (i > 0) chk("t_clamp", (i - 1) == 15, 3, 7);
        end

        // 5: reconfigure mid-stream together with a sample
        load(2, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 0, 10);
        cyc(1'b0, 1'b1, 0, 20);
        cyc(1'b0, 1'b1, 0, 30);
        cyc(1'b0, 1'b1, 0, 40);
        cyc(1'b0, 1'b1, 0, 50);  chk("t5_pre", 1'b1, 0, 25);
        i_cfg_log2n = 3'd1;
        cyc(1'b1, 1'b1, 0, 60);  chk("t5_inflight", 1'b0, 0, 0);
        chk_data("t5_hold", 25);
        cyc(1'b0, 1'b1, 0, 100); chk("t5_dropped", 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 0, 200); chk("t5_warm", 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0);   chk("t5_mean", 1'b1, 0, 150);

        // 6: reset mid-stream
        cyc(1'b0, 1'b1, 3, 500);
        cyc(1'b0, 1'b1, 3, 500);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 3, 55);
        rst = 1'b0;
        chk("t6_rst", 1'b0, 0, 0);
        chk_data("t6_rst", 0);
        cyc(1'b0, 1'b1, 1, 77);  chk("t6_after", 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 0, 0);   chk("t6_pass", 1'b1, 1, 77);
        cyc(1'b0, 1'b0, 0, 0);   chk("t6_idle", 1'b0, 0, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
